// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcode encoding and opcode typedef.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_XOR = 3'b011,
        OP_NOR = 3'b100,
        OP_SRL = 3'b101,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_if.sv
// Operand/result bundle between the ALU wrapper and its combinational datapath.
// Optional feature macro: ALU_OVERFLOW_EN adds the signed-overflow flag.
interface alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alu_op_e          op;
    logic [WIDTH-1:0] result;
    logic             zero;
`ifdef ALU_OVERFLOW_EN
    logic             overflow;
`endif

    // Master presents operands and consumes the computed result.
    modport master (
        output a, b, op,
`ifdef ALU_OVERFLOW_EN
        input  overflow,
`endif
        input  result, zero
    );

    // Slave is the datapath: consumes operands, produces the result.
    modport slave (
        input  a, b, op,
`ifdef ALU_OVERFLOW_EN
        output overflow,
`endif
        output result, zero
    );

endinterface : alu_if

// File: rtl/alu_datapath.sv
// Purely combinational ALU datapath: eight operations plus zero detect.
// Optional feature macro: ALU_OVERFLOW_EN adds signed ADD/SUB overflow detect.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    alu_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SHW-1:0]   w_shamt;
    logic             w_slt;
    logic [WIDTH-1:0] w_res;

    // Adder and subtractor wrap naturally; the carry-out is never formed.
    assign w_sum   = bus.a + bus.b;
    assign w_diff  = bus.a - bus.b;
    // Only the low shift field of A steers the shifter; higher bits are ignored.
    assign w_shamt = bus.a[SHW-1:0];
    assign w_slt   = ($signed(bus.a) < $signed(bus.b));

    // Operation select.
    always_comb begin
        w_res = '0;
        case (bus.op)
            OP_AND:  w_res = bus.a & bus.b;
            OP_OR:   w_res = bus.a | bus.b;
            OP_ADD:  w_res = w_sum;
            OP_XOR:  w_res = bus.a ^ bus.b;
            OP_NOR:  w_res = ~(bus.a | bus.b);
            OP_SRL:  w_res = bus.b >> w_shamt;
            OP_SUB:  w_res = w_diff;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
            default: w_res = '0;
        endcase
    end

    assign bus.result = w_res;
    // Zero comes from the same computed value that gets registered as Result.
    assign bus.zero   = (w_res == '0);

`ifdef ALU_OVERFLOW_EN
    logic w_add_ovf;
    logic w_sub_ovf;

    // Signed overflow: ADD when like-signed operands give an unlike-signed sum,
    // SUB when unlike-signed operands give a difference whose sign differs from A.
    assign w_add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1]  != bus.a[WIDTH-1]);
    assign w_sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
    assign bus.overflow = ((bus.op == OP_ADD) && w_add_ovf) ||
                          ((bus.op == OP_SUB) && w_sub_ovf);
`endif

endmodule : alu_datapath

// File: rtl/alu_unit.sv
// Registered ALU: combinational datapath followed by one stage of output flops.
// Optional feature macro: ALU_OVERFLOW_EN adds the registered Overflow output.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_operation,
`ifdef ALU_OVERFLOW_EN
    output logic             Overflow,
`endif
    output logic [WIDTH-1:0] Result,
    output logic             Zero
);

    alu_if #(.WIDTH(WIDTH)) u_bus ();

    assign u_bus.a  = A;
    assign u_bus.b  = B;
    assign u_bus.op = alu_op_e'(ALU_operation);

    alu_datapath #(.WIDTH(WIDTH)) u_datapath (
        .bus (u_bus.slave)
    );

    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    // Output stage: reset wins over the operation presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            r_result <= u_bus.result;
            r_zero   <= u_bus.zero;
        end
    end

    assign Result = r_result;
    assign Zero   = r_zero;

`ifdef ALU_OVERFLOW_EN
    logic r_overflow;

    // Overflow flag registered alongside Result, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= u_bus.overflow;
        end
    end

    assign Overflow = r_overflow;
`endif

endmodule : alu_unit

// File: tb/tb_alu_unit.sv
// Directed-vector bench for alu_unit (honours ALU_OVERFLOW_EN when defined).
module tb_alu_unit;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;

    alu_if #(.WIDTH(WIDTH)) tb_bus ();

    int n_checks;
    int n_errors;
    logic [WIDTH-1:0] prev_res;

    alu_unit #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .A             (tb_bus.a),
        .B             (tb_bus.b),
        .ALU_operation (tb_bus.op),
`ifdef ALU_OVERFLOW_EN
        .Overflow      (tb_bus.overflow),
`endif
        .Result        (tb_bus.result),
        .Zero          (tb_bus.zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one operation at a falling edge; outputs must hold until the next
    // rising edge, then show the result one cycle later.
    task automatic apply(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input alu_op_e op, input logic [WIDTH-1:0] exp_res,
                         input logic exp_zero, input logic exp_ovf);
        tb_bus.a  = a;
        tb_bus.b  = b;
        tb_bus.op = op;
        #1;
        check({tag, "_hold"}, 64'(tb_bus.result), 64'(prev_res));
        @(negedge clk);
        check({tag, "_res"},  64'(tb_bus.result), 64'(exp_res));
        check({tag, "_zero"}, 64'(tb_bus.zero),   64'(exp_zero));
`ifdef ALU_OVERFLOW_EN
        check({tag, "_ovf"},  64'(tb_bus.overflow), 64'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unexpected x in overflow expectation");
`endif
        $display("txn %-10s A=%08h B=%08h op=%03b -> Result=%08h Zero=%0b",
                 tag, a, b, op, tb_bus.result, tb_bus.zero);
        prev_res = exp_res;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        tb_bus.a  = '0;
        tb_bus.b  = '0;
        tb_bus.op = OP_AND;

        repeat (3) @(negedge clk);
        check("rst_res",  64'(tb_bus.result), 64'h0);
        check("rst_zero", 64'(tb_bus.zero),   64'h1);
`ifdef ALU_OVERFLOW_EN
        check("rst_ovf",  64'(tb_bus.overflow), 64'h0);
`endif

        // Operation presented during reset is discarded.
        tb_bus.a  = 32'd5;
        tb_bus.b  = 32'd3;
        tb_bus.op = OP_ADD;
        @(negedge clk);
        check("rstop_res",  64'(tb_bus.result), 64'h0);
        check("rstop_zero", 64'(tb_bus.zero),   64'h1);
        $display("txn rst_add    A=00000005 B=00000003 held in reset -> Result=%08h", tb_bus.result);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_res",  64'(tb_bus.result), 64'h8);
        check("first_zero", 64'(tb_bus.zero),   64'h0);
        $display("txn first_add  A=00000005 B=00000003 after reset -> Result=%08h", tb_bus.result);
        prev_res = 32'd8;

        // A=1, B=1 across successive cycles.
        apply("and11",  32'd1, 32'd1, OP_AND, 32'h0000_0001, 1'b0, 1'b0);
        apply("nor11",  32'd1, 32'd1, OP_NOR, 32'hFFFF_FFFE, 1'b0, 1'b0);
        apply("or11",   32'd1, 32'd1, OP_OR,  32'h0000_0001, 1'b0, 1'b0);
        apply("srl11",  32'd1, 32'd1, OP_SRL, 32'h0000_0000, 1'b1, 1'b0);
        apply("add11",  32'd1, 32'd1, OP_ADD, 32'h0000_0002, 1'b0, 1'b0);
        apply("sub11",  32'd1, 32'd1, OP_SUB, 32'h0000_0000, 1'b1, 1'b0);
        apply("xor11",  32'd1, 32'd1, OP_XOR, 32'h0000_0000, 1'b1, 1'b0);
        apply("slt11",  32'd1, 32'd1, OP_SLT, 32'h0000_0000, 1'b1, 1'b0);

        // Mixed bit patterns.
        apply("xorpat", 32'hF0F0_F0F0, 32'hFF00_FF00, OP_XOR, 32'h0FF0_0FF0, 1'b0, 1'b0);
        apply("andpat", 32'hF0F0_F0F0, 32'hFF00_FF00, OP_AND, 32'hF000_F000, 1'b0, 1'b0);
        apply("orpat",  32'hF0F0_F0F0, 32'h0F00_0F00, OP_OR,  32'hFFF0_FFF0, 1'b0, 1'b0);

        // Wrap and overflow boundaries.
        apply("addwrap", 32'hFFFF_FFFF, 32'h0000_0001, OP_ADD, 32'h0000_0000, 1'b1, 1'b0);
        apply("addovf",  32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 1'b0, 1'b1);
        apply("subovf",  32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 1'b0, 1'b1);
        apply("subneg",  32'h0000_0003, 32'h0000_0005, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // Signed compare at the extremes.
        apply("sltmin",  32'h8000_0000, 32'h7FFF_FFFF, OP_SLT, 32'h0000_0001, 1'b0, 1'b0);
        apply("sltswap", 32'h7FFF_FFFF, 32'h8000_0000, OP_SLT, 32'h0000_0000, 1'b1, 1'b0);

        // Shifter: only the low shift field of A counts.
        apply("srl4",    32'h0000_0024, 32'hF000_0000, OP_SRL, 32'h0F00_0000, 1'b0, 1'b0);
        apply("srl0",    32'h0000_0000, 32'hF000_0000, OP_SRL, 32'hF000_0000, 1'b0, 1'b0);
        apply("srl31",   32'h0000_001F, 32'h8000_0000, OP_SRL, 32'h0000_0001, 1'b0, 1'b0);

        // Reset in mid-stream clears everything again.
        tb_bus.a  = 32'h7FFF_FFFF;
        tb_bus.b  = 32'h0000_0001;
        tb_bus.op = OP_ADD;
        rst_n     = 1'b0;
        @(negedge clk);
        check("rst2_res",  64'(tb_bus.result), 64'h0);
        check("rst2_zero", 64'(tb_bus.zero),   64'h1);
`ifdef ALU_OVERFLOW_EN
        check("rst2_ovf",  64'(tb_bus.overflow), 64'h0);
`endif
        $display("txn rst2       mid-stream reset -> Result=%08h Zero=%0b", tb_bus.result, tb_bus.zero);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_unit
